// File: rtl/cache_ctrl_if.sv
// Operation types and the request/response bundle between a client and cache_ctrl.
// The client drives an operation and holds it until ready_out, then returns to NOOP.
package ctrl_types_pkg;
  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;
endpackage

interface cache_ctrl_if #(
  parameter int KEY_WIDTH   = 30,
  parameter int VALUE_WIDTH = 64,
  parameter int NUM_ENTRIES = 8
);
  localparam int COUNT_WIDTH = $clog2(NUM_ENTRIES + 1);

  ctrl_types_pkg::operation_e operation_in;
  logic [KEY_WIDTH-1:0]       key_in;
  logic [VALUE_WIDTH-1:0]     value_in;
  logic                       ready_out;
  logic                       op_succ_out;
  logic [VALUE_WIDTH-1:0]     value_out;
  logic                       busy_out;
  logic [COUNT_WIDTH-1:0]     count_out;

  modport master (
    output operation_in, key_in, value_in,
    input  ready_out, op_succ_out, value_out, busy_out, count_out
  );

  modport slave (
    input  operation_in, key_in, value_in,
    output ready_out, op_succ_out, value_out, busy_out, count_out
  );
endinterface

// File: rtl/cache_ctrl.sv
// Fully associative key/value table with a sequential one-entry-per-cycle search.
// Each request runs IDLE -> SEARCH -> EXEC -> RESP -> WAIT_CLR and yields one ready pulse.
module cache_ctrl #(
  parameter int KEY_WIDTH   = 30,
  parameter int VALUE_WIDTH = 64,
  parameter int NUM_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.slave bus
);
  import ctrl_types_pkg::*;

  localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES);
  localparam int COUNT_WIDTH = $clog2(NUM_ENTRIES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEARCH   = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_RESP     = 3'd3;
  localparam logic [2:0] S_WAIT_CLR = 3'd4;

  localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_ENTRIES - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT  = COUNT_WIDTH'(NUM_ENTRIES);

  logic [2:0]             state_q;
  operation_e             op_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic                   hit_q;
  logic [IDX_WIDTH-1:0]   hit_idx_q;
  logic                   free_found_q;
  logic [IDX_WIDTH-1:0]   free_idx_q;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [KEY_WIDTH-1:0]   key_mem   [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] value_mem [NUM_ENTRIES];

  logic                   succ_q;
  logic [VALUE_WIDTH-1:0] value_out_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   accept;
  logic                   probe_hit;
  logic                   probe_free;
  logic                   do_write;
  logic                   do_alloc;
  logic                   do_delete;
  logic                   exec_succ;
  logic [IDX_WIDTH-1:0]   wr_idx;
  logic [VALUE_WIDTH-1:0] exec_value;

  assign accept = (state_q == S_IDLE) && (bus.operation_in != NOOP);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    probe_hit  = valid_q[idx_q] && (key_mem[idx_q] == key_q);
    probe_free = !valid_q[idx_q];
  end

  // Outcome of the latched request, evaluated only while in EXEC.
  always_comb begin
    do_write   = 1'b0;
    do_alloc   = 1'b0;
    do_delete  = 1'b0;
    exec_succ  = 1'b0;
    exec_value = '0;
    wr_idx     = hit_idx_q;
    if (state_q == S_EXEC) begin
      case (op_q)
        READ: begin
          exec_succ = hit_q;
          if (hit_q) exec_value = value_mem[hit_idx_q];
        end
        UPSERT: begin
          if (hit_q) begin
            do_write  = 1'b1;
            exec_succ = 1'b1;
          end else if (free_found_q) begin
            do_write  = 1'b1;
            do_alloc  = 1'b1;
            wr_idx    = free_idx_q;
            exec_succ = 1'b1;
          end
        end
        DELETE: begin
          do_delete = hit_q;
          exec_succ = hit_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: stored keys/values and the request copies carry no reset; only the valid bits
  // decide whether an entry exists, so a reset costs nothing on the wide storage.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      key_q   <= bus.key_in;
      value_q <= bus.value_in;
    end
    if (!rst && do_write) begin
      key_mem[wr_idx]   <= key_q;
      value_mem[wr_idx] <= value_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= NOOP;
      idx_q        <= '0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      valid_q      <= '0;
      succ_q       <= 1'b0;
      value_out_q  <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q         <= bus.operation_in;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            free_found_q <= 1'b0;
            state_q      <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (probe_free && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          if (probe_hit) begin
            hit_q     <= 1'b1;
            hit_idx_q <= idx_q;
            state_q   <= S_EXEC;
          end else if (idx_q == LAST_IDX) begin
            state_q <= S_EXEC;
          end else begin
            idx_q <= idx_q + IDX_WIDTH'(1);
          end
        end
        S_EXEC: begin
          succ_q      <= exec_succ;
          value_out_q <= exec_value;
          if (do_alloc) begin
            valid_q[wr_idx] <= 1'b1;
            if (count_q != FULL_CNT) count_q <= count_q + COUNT_WIDTH'(1);
          end
          if (do_delete) begin
            valid_q[hit_idx_q] <= 1'b0;
            if (count_q != '0) count_q <= count_q - COUNT_WIDTH'(1);
          end
          state_q <= S_RESP;
        end
        S_RESP: state_q <= S_WAIT_CLR;
        S_WAIT_CLR: begin
          // A held request must be dropped to NOOP before another one is accepted.
          if (bus.operation_in == NOOP) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_out   = (state_q == S_RESP);
  assign bus.busy_out    = (state_q != S_IDLE);
  assign bus.op_succ_out = succ_q;
  assign bus.value_out   = value_out_q;
  assign bus.count_out   = count_q;
endmodule
